imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the decode stage. Accepts 32-bit instruction words over a valid/ready handshake, extracts and sign-extends the immediate for every RV base format (I, S, B, U, J), and reports the format and an illegal-opcode flag. Output is XLEN wide. A 2-entry skid buffer lets it sit between fetch and execute without combinational ready paths.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64.
SHAMT_W, 5, shift-amount width; 5 when XLEN=32, 6 when XLEN=64.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  inst_code valid
in_ready  output  1  block can accept inst_code this cycle
inst_code  input  32  instruction word
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
imm_out  output  XLEN  extended immediate
imm_fmt  output  3  format: NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6
illegal  output  1  opcode not recognised

Behaviour:
- Reset: one clock, reset is synchronous and active-high on clk/reset. Reset clears out_valid, imm_out, imm_fmt, illegal and skid_valid to 0, so in_ready=1 on the first cycle after reset.
- Reset mid-operation discards all held entries; no result appears after reset deasserts.
- Handshake: transfer when valid&&ready. Latency is 1 cycle from input accept to out_valid. out_valid, imm_out, imm_fmt and illegal stay stable while out_valid&&!out_ready.
- Main register updates when it is empty or out_ready=1.
- When the main register is stalled and an input is accepted, the input goes to the skid entry.
- in_ready = !skid_valid, registered, with no combinational path from out_ready.
- When out_ready=1 and the skid entry is full, skid moves to main in the same cycle and skid_valid clears.
- Ordering is strictly FIFO. There is no loss or duplication with simultaneous in and out handshakes.
- Decode on inst_code[6:0], sign bit s = inst[31], sext to XLEN:
  - 0000011 load, 1100111 JALR, 0010011 OP-IMM: I-type, sext(inst[31:20]).
  - Exception: OP-IMM with funct3 001 or 101 is a shift. imm = zero-ext inst[20+SHAMT_W-1:20], fmt I.
  - 0011011 OP-IMM-32, only when XLEN=64: same I-type rule, shamt fixed at 5 bits.
  - 0100011: S-type, sext({inst[31:25],inst[11:7]}).
  - 1100011: B-type, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U-type, sext({inst[31:12],12'b0}).
  - 1101111 JAL: J-type, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}), a 21-bit field.
  - 0110011, 0111011 (R-type) and 0001111 (FENCE): imm=0, fmt NONE, illegal=0.
  - Any other opcode: imm=0, fmt NONE, illegal=1.
- Width rule: sign extension always replicates inst[31] up to bit XLEN-1. No truncation is permitted.

Optional Feature:
IMM_GEN_ZICSR_EN
- Defined: opcode 1110011 with funct3 in {101,110,111} yields imm = zero-ext inst[19:15], fmt Z.
  - funct3 in {001,010,011} yields imm = zero-ext inst[31:20], fmt I.
  - funct3 000 (ECALL/EBREAK) yields imm=0, fmt NONE.
  - illegal=0 in all three cases.
- Undefined: opcode 1110011 is treated as unknown: imm=0, fmt NONE, illegal=1.

Decomposition:
- Package imm_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OPIMM32, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP32, OPC_FENCE, OPC_SYSTEM);
  - typedef enum logic [2:0] imm_fmt_e;
  - a packed struct imm_res_t {imm, fmt, illegal}, parametrised by XLEN through the module.
- One sub-module, imm_decode: purely combinational inst_code to imm_res_t, parametrised by XLEN.
- imm_gen_pipe instantiates imm_decode at its input and holds the main and skid registers of imm_res_t.

Test Plan:
- XLEN=32, inst 0xFFF00093 (ADDI -1), out_ready=1 -> next cycle out_valid=1, imm 0xFFFFFFFF, fmt I, illegal 0.
- inst 0x800000EF (JAL) -> imm 0xFFF00000, fmt J. Inst 0x80000063 (BEQ) -> imm 0xFFFFF000, fmt B. Inst 0x12345037 (LUI) -> imm 0x12345000, fmt U.
- Backpressure: out_ready=0 while 3 back-to-back inputs are offered -> 2 accepted, in_ready=0 on the third. Releasing out_ready outputs them in order with no drop or duplicate.
- XLEN=64: 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF. SLLI 0x03F09093 -> imm 0x3F. Inst 0x0000007F -> illegal=1, imm 0.
- IMM_GEN_ZICSR_EN defined: 0x3007D073 (CSRRWI) -> imm 0x0000000F, fmt Z. Same inst without the macro -> illegal=1.
- reset asserted while both registers are full -> next cycle out_valid=0, in_ready=1, outputs 0, and no stale result after release.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate format encoding and result record for the
// decode-stage immediate generator.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  // Widest form of the result record; modules re-declare it at their own XLEN
  // and hand that type to imm_decode through its res_t parameter.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_e            fmt;
    logic                illegal;
  } imm_res_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction-word to immediate decoder for the RV base formats.
// CSR immediates are decoded only when IMM_GEN_ZICSR_EN is defined.
module imm_decode
  import imm_pkg::*;
#(
  parameter int  XLEN    = 32,
  parameter int  SHAMT_W = 5,
  parameter type res_t   = imm_res_t
) (
  input  logic [31:0] inst_code,
  output res_t        res
);

  logic [XLEN-1:0] imm_v;
  imm_fmt_e        fmt_v;
  logic            ill_v;
  logic [2:0]      funct3;
  logic            s;

  // Replicates bit 31 of a 32-bit pattern all the way up to XLEN-1.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  assign funct3 = inst_code[14:12];
  assign s      = inst_code[31];

  always_comb begin
    imm_v = '0;
    fmt_v = FMT_NONE;
    ill_v = 1'b0;
    case (inst_code[6:0])
      OPC_LOAD, OPC_JALR: begin
        imm_v = sext32({{20{s}}, inst_code[31:20]});
        fmt_v = FMT_I;
      end
      OPC_OPIMM: begin
        fmt_v = FMT_I;
        if (funct3 == 3'b001 || funct3 == 3'b101)
          imm_v[SHAMT_W-1:0] = inst_code[20 +: SHAMT_W];
        else
          imm_v = sext32({{20{s}}, inst_code[31:20]});
      end
      OPC_OPIMM32: begin
        // Word shifts only exist on RV64 and always carry a 5-bit shamt.
        if (XLEN == 64) begin
          fmt_v = FMT_I;
          if (funct3 == 3'b001 || funct3 == 3'b101)
            imm_v[4:0] = inst_code[24:20];
          else
            imm_v = sext32({{20{s}}, inst_code[31:20]});
        end else begin
          ill_v = 1'b1;
        end
      end
      OPC_STORE: begin
        imm_v = sext32({{20{s}}, inst_code[31:25], inst_code[11:7]});
        fmt_v = FMT_S;
      end
      OPC_BRANCH: begin
        imm_v = sext32({{19{s}}, s, inst_code[7], inst_code[30:25],
                        inst_code[11:8], 1'b0});
        fmt_v = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_v = sext32({inst_code[31:12], 12'b0});
        fmt_v = FMT_U;
      end
      OPC_JAL: begin
        imm_v = sext32({{11{s}}, s, inst_code[19:12], inst_code[20],
                        inst_code[30:21], 1'b0});
        fmt_v = FMT_J;
      end
      OPC_OP, OPC_OP32, OPC_FENCE: begin
        fmt_v = FMT_NONE;
      end
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM: begin
        case (funct3)
          3'b101, 3'b110, 3'b111: begin
            imm_v[4:0] = inst_code[19:15];
            fmt_v      = FMT_Z;
          end
          3'b001, 3'b010, 3'b011: begin
            imm_v[11:0] = inst_code[31:20];
            fmt_v       = FMT_I;
          end
          3'b000: fmt_v = FMT_NONE;
          default: ill_v = 1'b1;
        endcase
      end
`endif
      default: ill_v = 1'b1;
    endcase
  end

  assign res = '{imm: imm_v, fmt: fmt_v, illegal: ill_v};

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (main + skid).
// Optional CSR immediate decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_code,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      imm_fmt,
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } res_t;

  res_t dec;
  res_t main_q;
  res_t skid_q;
  logic skid_valid;
  logic accept;
  logic main_load;

  imm_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W),
    .res_t   (res_t)
  ) u_decode (
    .inst_code (inst_code),
    .res       (dec)
  );

  // Handshake: a beat moves on a side whenever valid && ready are both high at
  // a rising clk edge; in_ready depends only on the skid flop, never on out_ready.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (main_load) begin
      // Older skid entry has priority; while it is held in_ready is low, so
      // no new beat can be accepted in the same cycle.
      if (skid_valid) begin
        main_q     <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign imm_out = main_q.imm;
  assign imm_fmt = main_q.fmt;
  assign illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Table-driven bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances run side by
// side, expected records are queued on input accept and popped on output.
module tb_imm_gen_pipe;

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_Z    = 3'd6;
  localparam int NV = 19;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] inst_code;
  logic        out_ready;
  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  vec_t        vecs[NV];
  logic [67:0] exp32_q[$];
  logic [67:0] exp64_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          rand_bp = 1'b0;

  imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) dut32 (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready32),
    .inst_code (inst_code), .out_valid (out_valid32), .out_ready (out_ready),
    .imm_out (imm32), .imm_fmt (fmt32), .illegal (ill32)
  );

  imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) dut64 (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready64),
    .inst_code (inst_code), .out_valid (out_valid64), .out_ready (out_ready),
    .imm_out (imm64), .imm_fmt (fmt64), .illegal (ill64)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx);
    exp32_q.push_back({32'h0, vecs[idx].imm32, vecs[idx].fmt32, vecs[idx].ill32});
    exp64_q.push_back({vecs[idx].imm64, vecs[idx].fmt64, vecs[idx].ill64});
  endtask

  // Scoreboard: compare every output beat against the oldest queued record.
  always @(negedge clk) begin
    logic [67:0] e;
    if (!reset && out_ready) begin
      if (out_valid32) begin
        if (exp32_q.size() == 0) begin
          check("unexpected_out32", {32'h0, imm32}, 64'hDEAD);
        end else begin
          e = exp32_q.pop_front();
          check("imm32", {32'h0, imm32}, e[67:4]);
          check("fmt32", {61'h0, fmt32}, {61'h0, e[3:1]});
          check("ill32", {63'h0, ill32}, {63'h0, e[0]});
        end
      end
      if (out_valid64) begin
        if (exp64_q.size() == 0) begin
          check("unexpected_out64", imm64, 64'hDEAD);
        end else begin
          e = exp64_q.pop_front();
          check("imm64", imm64, e[67:4]);
          check("fmt64", {61'h0, fmt64}, {61'h0, e[3:1]});
          check("ill64", {63'h0, ill64}, {63'h0, e[0]});
        end
      end
    end
  end

  task automatic send(input int idx);
    int n;
    in_valid  = 1'b1;
    inst_code = vecs[idx].inst;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready32 && in_ready64) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
    end
    push_exp(idx);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp32_q.size() == 0 && exp64_q.size() == 0) break;
    end
    check("drain32_left", 64'(exp32_q.size()), 64'd0);
    check("drain64_left", 64'(exp64_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid32"}, {63'h0, out_valid32}, 64'd0);
    check({tag, "_out_valid64"}, {63'h0, out_valid64}, 64'd0);
    check({tag, "_in_ready32"}, {63'h0, in_ready32}, 64'd1);
    check({tag, "_in_ready64"}, {63'h0, in_ready64}, 64'd1);
    check({tag, "_imm32"}, {32'h0, imm32}, 64'd0);
    check({tag, "_imm64"}, imm64, 64'd0);
    check({tag, "_fmt32"}, {61'h0, fmt32}, 64'd0);
    check({tag, "_fmt64"}, {61'h0, fmt64}, 64'd0);
    check({tag, "_ill32"}, {63'h0, ill32}, 64'd0);
    check({tag, "_ill64"}, {63'h0, ill64}, 64'd0);
  endtask

  initial begin
    int n;
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, F_I, 1'b0, 64'hFFFFFFFF_FFFFFFFF, F_I, 1'b0};
    vecs[1]  = '{32'h800000EF, 32'hFFF00000, F_J, 1'b0, 64'hFFFFFFFF_FFF00000, F_J, 1'b0};
    vecs[2]  = '{32'h80000063, 32'hFFFFF000, F_B, 1'b0, 64'hFFFFFFFF_FFFFF000, F_B, 1'b0};
    vecs[3]  = '{32'h12345037, 32'h12345000, F_U, 1'b0, 64'h00000000_12345000, F_U, 1'b0};
    vecs[4]  = '{32'h03F09093, 32'h0000001F, F_I, 1'b0, 64'h00000000_0000003F, F_I, 1'b0};
    vecs[5]  = '{32'h0000007F, 32'h00000000, F_NONE, 1'b1, 64'h0, F_NONE, 1'b1};
    vecs[6]  = '{32'hFE20AE23, 32'hFFFFFFFC, F_S, 1'b0, 64'hFFFFFFFF_FFFFFFFC, F_S, 1'b0};
    vecs[7]  = '{32'h002081B3, 32'h00000000, F_NONE, 1'b0, 64'h0, F_NONE, 1'b0};
    vecs[8]  = '{32'h0FF0000F, 32'h00000000, F_NONE, 1'b0, 64'h0, F_NONE, 1'b0};
    vecs[9]  = '{32'hFFF0009B, 32'h00000000, F_NONE, 1'b1, 64'hFFFFFFFF_FFFFFFFF, F_I, 1'b0};
    vecs[10] = '{32'h40F0D093, 32'h0000000F, F_I, 1'b0, 64'h00000000_0000000F, F_I, 1'b0};
    vecs[11] = '{32'h7FF08067, 32'h000007FF, F_I, 1'b0, 64'h00000000_000007FF, F_I, 1'b0};
    vecs[12] = '{32'hFFFFF097, 32'hFFFFF000, F_U, 1'b0, 64'hFFFFFFFF_FFFFF000, F_U, 1'b0};
    vecs[13] = '{32'h0080006F, 32'h00000008, F_J, 1'b0, 64'h00000000_00000008, F_J, 1'b0};
`ifdef IMM_GEN_ZICSR_EN
    vecs[14] = '{32'h3007D073, 32'h0000000F, F_Z, 1'b0, 64'h00000000_0000000F, F_Z, 1'b0};
    vecs[15] = '{32'h30002573, 32'h00000300, F_I, 1'b0, 64'h00000000_00000300, F_I, 1'b0};
`else
    vecs[14] = '{32'h3007D073, 32'h00000000, F_NONE, 1'b1, 64'h0, F_NONE, 1'b1};
    vecs[15] = '{32'h30002573, 32'h00000000, F_NONE, 1'b1, 64'h0, F_NONE, 1'b1};
`endif
    vecs[16] = '{32'h80002083, 32'hFFFFF800, F_I, 1'b0, 64'hFFFFFFFF_FFFFF800, F_I, 1'b0};
    vecs[17] = '{32'h01F0909B, 32'h00000000, F_NONE, 1'b1, 64'h00000000_0000001F, F_I, 1'b0};
    vecs[18] = '{32'h0020853B, 32'h00000000, F_NONE, 1'b0, 64'h0, F_NONE, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0;
    inst_code = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;

    // Pass 1: free-flowing output, one vector at a time.
    for (int i = 0; i < NV; i++) send(i);
    drain();

    // Pass 2: back-to-back inputs under random output backpressure.
    rand_bp = 1'b1;
    fork
      begin
        while (rand_bp) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < NV; i++) send($urandom_range(0, NV - 1));
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    drain();

    // Stall: two beats fill main and skid, the third must be refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_code = vecs[0].inst;
    @(negedge clk);
    check("bp_ready_first", {63'h0, in_ready32}, 64'd1);
    push_exp(0);
    @(posedge clk);
    #1 inst_code = vecs[1].inst;
    @(negedge clk);
    check("bp_ready_second", {63'h0, in_ready32}, 64'd1);
    push_exp(1);
    @(posedge clk);
    #1 inst_code = vecs[3].inst;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_ready_full32", {63'h0, in_ready32}, 64'd0);
      check("bp_ready_full64", {63'h0, in_ready64}, 64'd0);
      check("bp_hold_valid", {63'h0, out_valid32}, 64'd1);
      check("bp_hold_imm32", {32'h0, imm32}, 64'hFFFFFFFF);
      check("bp_hold_fmt64", {61'h0, fmt64}, {61'h0, F_I});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready32 && in_ready64) break;
      n++;
      if (n > 20) begin
        check("bp_release_timeout", 64'(n), 64'd0);
        break;
      end
    end
    push_exp(3);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Reset with both entries held: everything is discarded.
    out_ready = 1'b0;
    send(6);
    send(2);
    @(negedge clk);
    check("rst_pre_full", {63'h0, in_ready32}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp32_q.delete();
    exp64_q.delete();
    @(negedge clk);
    check_idle("midreset");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stale32", {63'h0, out_valid32}, 64'd0);
      check("stale64", {63'h0, out_valid64}, 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
